frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Frame-level controller upstream of the crosshair drawer and the wall renderer. Owns the VGA write port.
- On each frame tick it runs three stages in order: clear the screen (ceiling/floor fill), then the render pass, then the crosshair.
- Each external drawer is started with a one-cycle start pulse and finishes with a one-cycle done pulse.
- The sequencer multiplexes the active stage's pixel writes onto the single adapter interface.

Parameters:
- SCREEN_W, 160, pixel columns; x range 0..SCREEN_W-1.
- SCREEN_H, 120, pixel rows; y range 0..SCREEN_H-1.
- HORIZON, 60, first floor row; rows with y < HORIZON are ceiling.
- CEIL_COLOUR, 18'h0_0FFF, 18-bit ceiling colour.
- FLOOR_COLOUR, 18'h1_5555, 18-bit floor colour.
- XHAIR_X, 80, crosshair centre column.
- XHAIR_Y, 60, crosshair centre row.
- WATCHDOG_CYCLES, 65535, timeout per external stage (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse requesting a new frame.
- render_start  out  1  one-cycle start pulse to the renderer.
- render_done  in  1  one-cycle done pulse from the renderer.
- render_x  in  8  renderer pixel x.
- render_y  in  7  renderer pixel y.
- render_colour  in  18  renderer pixel colour.
- render_write  in  1  renderer write strobe.
- xhair_start  out  1  start pulse to the crosshair drawer.
- xhair_done  in  1  done pulse from the crosshair drawer.
- xhair_center_x  out  8  constant XHAIR_X.
- xhair_center_y  out  7  constant XHAIR_Y.
- xhair_x  in  8  crosshair pixel x.
- xhair_y  in  7  crosshair pixel y.
- xhair_colour  in  18  crosshair pixel colour.
- xhair_write  in  1  crosshair write strobe.
- vga_x  out  8  adapter x.
- vga_y  out  7  adapter y.
- vga_colour  out  18  adapter colour.
- vga_write  out  1  adapter write strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overrun_count  out  8  saturating count of dropped frame_ticks.
- timeout_flag  out  1  sticky watchdog flag.

Behaviour:
- Reset (any cycle, including mid-frame):
  - state=IDLE; clear counters x=0, y=0; overrun_count=0; timeout_flag=0.
  - All start pulses, vga_write and frame_done are 0.
  - vga_x, vga_y and vga_colour are 0.
  - Stage operations in progress are abandoned, not resumed.
- States and transitions:
  - IDLE: on frame_tick, go to CLEAR with x=0, y=0.
  - CLEAR: one pixel per cycle; vga_write=1, vga_x=x, vga_y=y; vga_colour = CEIL_COLOUR if y<HORIZON, else FLOOR_COLOUR.
    - x increments each cycle; at x=SCREEN_W-1 it wraps to 0 and y increments.
    - After writing (SCREEN_W-1, SCREEN_H-1), go to START_RENDER. This is exactly SCREEN_W*SCREEN_H writes (19200 at defaults), in raster order.
  - START_RENDER: render_start=1 for this cycle; go to WAIT_RENDER.
  - WAIT_RENDER: vga_* = render_* passthrough (combinational). On render_done, go to START_XHAIR.
  - START_XHAIR: xhair_start=1; go to WAIT_XHAIR.
  - WAIT_XHAIR: vga_* = xhair_* passthrough. On xhair_done, go to FRAME_DONE.
  - FRAME_DONE: frame_done=1; go to IDLE.
- Write gating:
  - In the START_* and FRAME_DONE states, vga_write=0 and vga_x, vga_y, vga_colour=0.
  - Client write strobes are ignored outside that client's WAIT state.
- Done sampling:
  - render_done and xhair_done are sampled only in their own WAIT state; a done in any other state is ignored.
  - A done arriving in the same cycle as the client's own write is legal; that write still passes through.
- frame_tick:
  - A tick in any state other than IDLE, including FRAME_DONE, is dropped and increments overrun_count. The count saturates at 255.
  - Ticks are never queued; the next frame starts on the first tick seen in IDLE.
- Latency: frame_tick to first clear write is 1 cycle. With zero-length clients a full frame is 19200+N cycles, where N is fixed by the state sequence above.

Optional Feature:
- Macro: FRAME_SEQ_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to each WAIT state and increments every cycle there.
  - When it reaches WATCHDOG_CYCLES without the stage's done, the FSM advances as if done had arrived and sets timeout_flag.
  - timeout_flag stays set until reset.
- Undefined: WAIT states wait indefinitely; timeout_flag is tied to 0 and no counter is instantiated.

Test Plan:
- Reset then idle 10 cycles -> vga_write=0, busy=0, all pulses 0, overrun_count=0.
- frame_tick with stub clients answering done 5 cycles after start:
  - exactly 19200 clear writes; first (0,0)=CEIL_COLOUR, (0,59)=CEIL_COLOUR, (0,60)=FLOOR_COLOUR, last (159,119)=FLOOR_COLOUR.
  - render_start 1 cycle after the last write; xhair_start after render_done; one frame_done pulse; busy drops.
- Renderer stub writes (10,20,18'h3FFFF) while in WAIT_RENDER -> identical values on vga_*. The same stub writing during WAIT_XHAIR -> not forwarded.
- 300 frame_ticks during CLEAR -> overrun_count saturates at 255. A tick in FRAME_DONE -> counted. The next tick in IDLE -> a new frame starts.
- Reset asserted at clear pixel (50,30) -> next cycle IDLE, vga_write=0. A fresh tick restarts the clear at (0,0).
- FRAME_SEQ_WATCHDOG_EN with WATCHDOG_CYCLES=100 and a renderer that never answers -> xhair_start follows 100 cycles after entering WAIT_RENDER and timeout_flag=1. Without the macro -> still in WAIT_RENDER after 10000 cycles.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame clear / render / crosshair sequencing onto the single VGA write port.
// Optional macro FRAME_SEQ_WATCHDOG_EN adds a per-stage timeout and the sticky timeout_flag_o.
module frame_sequencer #(
    parameter int unsigned SCREEN_W        = 160,
    parameter int unsigned SCREEN_H        = 120,
    parameter int unsigned HORIZON         = 60,
    parameter logic [17:0] CEIL_COLOUR     = 18'h0_0FFF,
    parameter logic [17:0] FLOOR_COLOUR    = 18'h1_5555,
    parameter int unsigned XHAIR_X         = 80,
    parameter int unsigned XHAIR_Y         = 60,
    parameter int unsigned WATCHDOG_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick_i,
    output logic        render_start_o,
    input  logic        render_done_i,
    input  logic [7:0]  render_x_i,
    input  logic [6:0]  render_y_i,
    input  logic [17:0] render_colour_i,
    input  logic        render_write_i,
    output logic        xhair_start_o,
    input  logic        xhair_done_i,
    output logic [7:0]  xhair_center_x_o,
    output logic [6:0]  xhair_center_y_o,
    input  logic [7:0]  xhair_x_i,
    input  logic [6:0]  xhair_y_i,
    input  logic [17:0] xhair_colour_i,
    input  logic        xhair_write_i,
    output logic [7:0]  vga_x_o,
    output logic [6:0]  vga_y_o,
    output logic [17:0] vga_colour_o,
    output logic        vga_write_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [7:0]  overrun_count_o,
    output logic        timeout_flag_o
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, START_RENDER, WAIT_RENDER, START_XHAIR, WAIT_XHAIR, FRAME_DONE
    } state_t;
    state_t      state_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [7:0]  overrun_q;
    logic        last_x, last_y, render_go, xhair_go;
    assign last_x = x_q == 8'(SCREEN_W - 1);
    assign last_y = y_q == 7'(SCREEN_H - 1);
`ifdef FRAME_SEQ_WATCHDOG_EN
    logic [15:0] wd_q;
    logic        timeout_q, wd_hit, in_wait;
    assign in_wait   = state_q == WAIT_RENDER || state_q == WAIT_XHAIR;
    assign wd_hit    = (wd_q + 16'd1) == 16'(WATCHDOG_CYCLES);
    assign render_go = render_done_i | wd_hit;
    assign xhair_go  = xhair_done_i | wd_hit;
    assign timeout_flag_o = timeout_q;
    // Counter sits at zero outside the WAIT states, so it restarts on every WAIT entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= in_wait ? wd_q + 16'd1 : '0;
            if (wd_hit && ((state_q == WAIT_RENDER && !render_done_i) ||
                           (state_q == WAIT_XHAIR && !xhair_done_i)))
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_wd;
    assign unused_wd      = ^WATCHDOG_CYCLES;
    assign render_go      = render_done_i;
    assign xhair_go       = xhair_done_i;
    assign timeout_flag_o = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            overrun_q <= '0;
        end else begin
            if (frame_tick_i && state_q != IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
            case (state_q)
                IDLE: if (frame_tick_i) begin
                    state_q <= CLEAR;
                    x_q     <= '0;
                    y_q     <= '0;
                end
                CLEAR: begin
                    x_q <= last_x ? '0 : x_q + 8'd1;
                    if (last_x) y_q <= y_q + 7'd1;
                    if (last_x && last_y) state_q <= START_RENDER;
                end
                START_RENDER: state_q <= WAIT_RENDER;
                WAIT_RENDER:  if (render_go) state_q <= START_XHAIR;
                START_XHAIR:  state_q <= WAIT_XHAIR;
                WAIT_XHAIR:   if (xhair_go) state_q <= FRAME_DONE;
                default:      state_q <= IDLE;
            endcase
        end
    end
    // Only the active stage reaches the adapter; everything else drives zeros.
    assign vga_write_o  = state_q == CLEAR ||
                          (state_q == WAIT_RENDER && render_write_i) ||
                          (state_q == WAIT_XHAIR && xhair_write_i);
    assign vga_x_o      = state_q == CLEAR ? x_q :
                          state_q == WAIT_RENDER ? render_x_i :
                          state_q == WAIT_XHAIR ? xhair_x_i : '0;
    assign vga_y_o      = state_q == CLEAR ? y_q :
                          state_q == WAIT_RENDER ? render_y_i :
                          state_q == WAIT_XHAIR ? xhair_y_i : '0;
    assign vga_colour_o = state_q == CLEAR ? (y_q < 7'(HORIZON) ? CEIL_COLOUR : FLOOR_COLOUR) :
                          state_q == WAIT_RENDER ? render_colour_i :
                          state_q == WAIT_XHAIR ? xhair_colour_i : '0;
    assign render_start_o   = state_q == START_RENDER;
    assign xhair_start_o    = state_q == START_XHAIR;
    assign frame_done_o     = state_q == FRAME_DONE;
    assign busy_o           = state_q != IDLE;
    assign overrun_count_o  = overrun_q;
    assign xhair_center_x_o = 8'(XHAIR_X);
    assign xhair_center_y_o = 7'(XHAIR_Y);
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench; expected output events are queued with their cycle stamp.
module tb_frame_sequencer;
    logic        clock = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic        render_start, render_done = 1'b0, render_write = 1'b0;
    logic [7:0]  render_x = '0;
    logic [6:0]  render_y = '0;
    logic [17:0] render_colour = '0;
    logic        xhair_start, xhair_done = 1'b0, xhair_write = 1'b0;
    logic [7:0]  xhair_cx, xhair_x = '0, vga_x, overrun;
    logic [6:0]  xhair_cy, xhair_y = '0, vga_y;
    logic [17:0] xhair_colour = '0, vga_colour;
    logic        vga_write, busy, frame_done, timeout_flag;
    int          cyc = 0, n_cmp = 0, n_bad = 0;

    localparam logic [3:0] K_WR = 4'b1000, K_RS = 4'b0100, K_XS = 4'b0010, K_FD = 4'b0001;
    typedef struct {
        logic [3:0]  k;
        int          c;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [17:0] col;
    } ev_t;
    ev_t exp_q[$];

    frame_sequencer #(.WATCHDOG_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .frame_tick_i(frame_tick),
        .render_start_o(render_start), .render_done_i(render_done),
        .render_x_i(render_x), .render_y_i(render_y), .render_colour_i(render_colour),
        .render_write_i(render_write),
        .xhair_start_o(xhair_start), .xhair_done_i(xhair_done),
        .xhair_center_x_o(xhair_cx), .xhair_center_y_o(xhair_cy),
        .xhair_x_i(xhair_x), .xhair_y_i(xhair_y), .xhair_colour_i(xhair_colour),
        .xhair_write_i(xhair_write),
        .vga_x_o(vga_x), .vga_y_o(vga_y), .vga_colour_o(vga_colour), .vga_write_o(vga_write),
        .busy_o(busy), .frame_done_o(frame_done), .overrun_count_o(overrun),
        .timeout_flag_o(timeout_flag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every visible output event must match the head of the expected queue.
    always @(negedge clock) begin
        if (vga_write || render_start || xhair_start || frame_done) begin
            ev_t g, e;
            g.k = {vga_write, render_start, xhair_start, frame_done};
            g.c = cyc; g.x = vga_x; g.y = vga_y; g.col = vga_colour;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got k=%b cyc=%0d x=%0d y=%0d col=%h, required none",
                         g.k, g.c, g.x, g.y, g.col);
            end else begin
                e = exp_q.pop_front();
                if (g.k != e.k || g.c != e.c || (g.k == K_WR &&
                    (g.x != e.x || g.y != e.y || g.col != e.col))) begin
                    n_bad++;
                    $display("FAIL event: got k=%b cyc=%0d x=%0d y=%0d col=%h, required k=%b cyc=%0d x=%0d y=%0d col=%h",
                             g.k, g.c, g.x, g.y, g.col, e.k, e.c, e.x, e.y, e.col);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic push(input logic [3:0] k, input int c, input logic [7:0] x,
                        input logic [6:0] y, input logic [17:0] col);
        ev_t e;
        e.k = k; e.c = c; e.x = x; e.y = y; e.col = col;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input int c, input int n);
        for (int k = 0; k < n; k++)
            push(K_WR, c + 1 + k, 8'(k % 160), 7'(k / 160), (k / 160) < 60 ? 18'h00FFF : 18'h15555);
    endtask

    // Full frame with clients answering 5 cycles after their start pulse.
    task automatic run_frame(input bit fd_tick, input int over_ticks);
        int c;
        c = cyc;
        frame_tick = 1'b1;
        push_clear(c, 19200);
        push(K_RS, c + 19201, 0, 0, 0);
        push(K_WR, c + 19206, 8'd10, 7'd20, 18'h3FFFF);
        push(K_XS, c + 19207, 0, 0, 0);
        push(K_WR, c + 19210, 8'd80, 7'd60, 18'h3F000);
        push(K_FD, c + 19213, 0, 0, 0);
        step();
        frame_tick = 1'b0;
        for (int i = 0; i < over_ticks; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
        render_done = 1'b1;
        step_to(c + 19200);
        chk("busy_in_clear", busy, 1);
        render_done = 1'b0;
        step_to(c + 19206);
        render_done = 1'b1; render_write = 1'b1;
        render_x = 8'd10; render_y = 7'd20; render_colour = 18'h3FFFF;
        step();
        render_done = 1'b0; render_write = 1'b0;
        step_to(c + 19209);
        render_write = 1'b1;
        step();
        render_write = 1'b0;
        xhair_write = 1'b1; xhair_x = 8'd80; xhair_y = 7'd60; xhair_colour = 18'h3F000;
        step();
        xhair_write = 1'b0;
        step_to(c + 19212);
        xhair_done = 1'b1;
        step();
        xhair_done = 1'b0;
        frame_tick = fd_tick;
        step();
        frame_tick = 1'b0;
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL time_limit: got no finish, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("reset_vga_write", vga_write, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {render_start, xhair_start, frame_done}, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_timeout", timeout_flag, 0);
        chk("reset_vga_bus", {vga_x, vga_y, vga_colour}, 0);
        chk("xhair_center", {xhair_cx, xhair_cy}, {8'd80, 7'd60});
        run_frame(1'b1, 0);
        chk("overrun_frame_done_tick", overrun, 1);
        run_frame(1'b0, 300);
        chk("overrun_saturated", overrun, 255);
        c = cyc;
        frame_tick = 1'b1;
        push_clear(c, 4851);
        step();
        frame_tick = 1'b0;
        step_to(c + 4851);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_write", vga_write, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_overrun", overrun, 0);
        c = cyc;
        frame_tick = 1'b1;
        push_clear(c, 3);
        step();
        frame_tick = 1'b0;
        step_to(c + 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        c = cyc;
        frame_tick = 1'b1;
        push_clear(c, 19200);
        push(K_RS, c + 19201, 0, 0, 0);
`ifdef FRAME_SEQ_WATCHDOG_EN
        push(K_XS, c + 19302, 0, 0, 0);
        step();
        frame_tick = 1'b0;
        step_to(c + 19301);
        chk("wd_not_yet", timeout_flag, 0);
        step();
        chk("wd_timeout_flag", timeout_flag, 1);
        step(); step();
        chk("wd_flag_sticky", timeout_flag, 1);
`else
        step();
        frame_tick = 1'b0;
        step_to(c + 19202 + 10000);
        chk("no_wd_still_busy", busy, 1);
        chk("no_wd_timeout", timeout_flag, 0);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("final_timeout_cleared", timeout_flag, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
